// File: rtl/game_flow_ctrl_if.sv
// Game sequencer bus: mouse, frame and point inputs plus the flow/score outputs.
// Latency: none, wires only.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface game_flow_ctrl_if;
    logic        left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        frame_tick;
    logic        point_p1;
    logic        point_p2;
    logic        enable_menu;
    logic        enable_game;
    logic        mousecontrol;
    logic        flag_point;
    logic        endgame;
    logic        winner;
    logic        serve_side;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;

    // Driver side: mouse/ball logic feeding the sequencer, reading its outputs.
    modport master (
        output left, xpos, ypos, frame_tick, point_p1, point_p2,
        input  enable_menu, enable_game, mousecontrol, flag_point, endgame,
        input  winner, serve_side, score_p1, score_p2
    );

    // Sequencer side.
    modport slave (
        input  left, xpos, ypos, frame_tick, point_p1, point_p2,
        output enable_menu, enable_game, mousecontrol, flag_point, endgame,
        output winner, serve_side, score_p1, score_p2
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: menu / play / point-pause / game-over flow, start-button click, scoring.
// Latency: every output is registered and reflects an input one clock edge later.
// Backpressure: none; clicks are edge-detected, point pulses outside PLAY are dropped.
module game_flow_ctrl #(
    parameter int unsigned BTN_X        = 340,
    parameter int unsigned BTN_Y        = 330,
    parameter int unsigned BTN_W        = 390,
    parameter int unsigned BTN_H        = 50,
    parameter int unsigned WIN_SCORE    = 15,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 180
) (
    input  logic           clk,
    input  logic           rst,
    game_flow_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Button bounds widened by one bit so BTN_X+BTN_W cannot wrap against 12-bit coordinates.
    localparam logic [12:0] X_LO      = 13'(BTN_X);
    localparam logic [12:0] X_HI      = 13'(BTN_X + BTN_W);
    localparam logic [12:0] Y_LO      = 13'(BTN_Y);
    localparam logic [12:0] Y_HI      = 13'(BTN_Y + BTN_H);
    localparam logic [8:0]  PAUSE_LIM = 9'(PAUSE_FRAMES);
    localparam logic [8:0]  OVER_LIM  = 9'(OVER_FRAMES);
    localparam logic [3:0]  WIN_LIM   = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic        left_prev_q, left_prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  score_p1_q, score_p1_d;
    logic [3:0]  score_p2_q, score_p2_d;
    logic        serve_q, serve_d;
    logic        winner_q, winner_d;
    logic        enable_menu_q, enable_menu_d;
    logic        enable_game_q, enable_game_d;
    logic        mousecontrol_q, mousecontrol_d;
    logic        flag_point_q, flag_point_d;
    logic        endgame_q, endgame_d;

    logic        click;
    logic        in_btn;
    logic [8:0]  cnt_inc;
    logic [3:0]  p1_inc;
    logic [3:0]  p2_inc;

    assign click   = bus.left & ~left_prev_q;
    assign in_btn  = ({1'b0, bus.xpos} >= X_LO) && ({1'b0, bus.xpos} <= X_HI) &&
                     ({1'b0, bus.ypos} >= Y_LO) && ({1'b0, bus.ypos} <= Y_HI);
    // The frame_tick being handled now is the (cnt_q+1)-th one in the current state.
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign p1_inc  = (score_p1_q == 4'hF) ? 4'hF : score_p1_q + 4'd1;
    assign p2_inc  = (score_p2_q == 4'hF) ? 4'hF : score_p2_q + 4'd1;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_MENU;
            left_prev_q    <= 1'b0;
            cnt_q          <= 8'd0;
            score_p1_q     <= 4'd0;
            score_p2_q     <= 4'd0;
            serve_q        <= 1'b0;
            winner_q       <= 1'b0;
            enable_menu_q  <= 1'b1;
            enable_game_q  <= 1'b0;
            mousecontrol_q <= 1'b0;
            flag_point_q   <= 1'b0;
            endgame_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            left_prev_q    <= left_prev_d;
            cnt_q          <= cnt_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            serve_q        <= serve_d;
            winner_q       <= winner_d;
            enable_menu_q  <= enable_menu_d;
            enable_game_q  <= enable_game_d;
            mousecontrol_q <= mousecontrol_d;
            flag_point_q   <= flag_point_d;
            endgame_q      <= endgame_d;
        end
    end

    // Next-state logic: flow transitions, scoring, frame counting.
    always_comb begin
        state_d     = state_q;
        left_prev_d = bus.left;
        cnt_d       = cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        serve_d     = serve_q;
        winner_d    = winner_q;
        case (state_q)
            ST_MENU: begin
                // Last match's scores stay on screen until a new match actually starts.
                if (click && in_btn) begin
                    state_d    = ST_PLAY;
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    serve_d    = 1'b0;
                    winner_d   = 1'b0;
                end
            end
            ST_PLAY: begin
                // Player 1 takes priority when both point pulses land together.
                if (bus.point_p1) begin
                    score_p1_d = p1_inc;
                    serve_d    = 1'b0;
                    cnt_d      = 8'd0;
                    if (p1_inc == WIN_LIM) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end else if (bus.point_p2) begin
                    score_p2_d = p2_inc;
                    serve_d    = 1'b1;
                    cnt_d      = 8'd0;
                    if (p2_inc == WIN_LIM) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.frame_tick) begin
                    if (cnt_inc >= PAUSE_LIM) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_inc[7:0];
                    end
                end
            end
            ST_OVER: begin
                if (click || (bus.frame_tick && (cnt_inc >= OVER_LIM))) begin
                    state_d = ST_MENU;
                end else if (bus.frame_tick) begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // Output decode from the next state so the flags land in their flops with the state.
    always_comb begin
        enable_menu_d  = 1'b0;
        enable_game_d  = 1'b0;
        mousecontrol_d = 1'b0;
        flag_point_d   = 1'b0;
        endgame_d      = 1'b0;
        case (state_d)
            ST_MENU: begin
                enable_menu_d = 1'b1;
            end
            ST_PLAY: begin
                enable_game_d  = 1'b1;
                mousecontrol_d = 1'b1;
            end
            ST_PAUSE: begin
                mousecontrol_d = 1'b1;
                flag_point_d   = 1'b1;
            end
            ST_OVER: begin
                enable_menu_d = 1'b1;
                endgame_d     = 1'b1;
            end
            default: begin
                enable_menu_d = 1'b1;
            end
        endcase
    end

    assign bus.enable_menu  = enable_menu_q;
    assign bus.enable_game  = enable_game_q;
    assign bus.mousecontrol = mousecontrol_q;
    assign bus.flag_point   = flag_point_q;
    assign bus.endgame      = endgame_q;
    assign bus.winner       = winner_q;
    assign bus.serve_side   = serve_q;
    assign bus.score_p1     = score_p1_q;
    assign bus.score_p2     = score_p2_q;

endmodule
